// File: rtl/stream_cmp.sv
// Streaming multi-word comparator: two N-word operands arrive most-significant word
// first, one pair per handshake. Reports eq/lt/gt, mismatch count and first mismatch index.
module stream_cmp #(
    parameter int W      = 8,
    parameter int N      = 4,
    parameter int SIGNED = 0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [W-1:0]                      a,
    input  logic [W-1:0]                      b,
    output logic                              done,
    output logic                              eq,
    output logic                              lt,
    output logic                              gt,
    output logic [$clog2(N+1)-1:0]            mism_cnt,
    output logic [(($clog2(N) > 1) ? $clog2(N) : 1)-1:0] first_idx
);

    localparam int CW = $clog2(N + 1);
    localparam int IW = ($clog2(N) > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic          decided;
    logic          dir_lt;
    logic [CW-1:0] cnt;
    logic [IW-1:0] fidx;

    logic          xfer;
    logic          diff;
    logic          last_word;
    logic          word_is_signed;
    logic          decided_nxt;
    logic          dir_lt_nxt;
    logic [CW-1:0] cnt_nxt;
    logic [IW-1:0] fidx_nxt;

    // Word-level ordering; only the leading word may carry a sign.
    function automatic logic word_lt(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic is_signed);
        logic signed [W-1:0] xs;
        logic signed [W-1:0] ys;
        xs = x;
        ys = y;
        if (is_signed)
            return xs < ys;
        return x < y;
    endfunction

    assign in_ready       = (state == S_RUN);
    assign done           = (state == S_DONE);
    assign xfer           = in_valid & in_ready;
    assign diff           = (a != b);
    assign last_word      = (idx == IW'(N - 1));
    assign word_is_signed = (SIGNED != 0) && (idx == '0);

    always_comb begin
        decided_nxt = decided;
        dir_lt_nxt  = dir_lt;
        cnt_nxt     = cnt;
        fidx_nxt    = fidx;
        if (diff) begin
            cnt_nxt = cnt + CW'(1);
            if (!decided) begin
                decided_nxt = 1'b1;
                dir_lt_nxt  = word_lt(a, b, word_is_signed);
                fidx_nxt    = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            decided   <= 1'b0;
            dir_lt    <= 1'b0;
            cnt       <= '0;
            fidx      <= '0;
            eq        <= 1'b0;
            lt        <= 1'b0;
            gt        <= 1'b0;
            mism_cnt  <= '0;
            first_idx <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_RUN;
                        idx       <= '0;
                        decided   <= 1'b0;
                        dir_lt    <= 1'b0;
                        cnt       <= '0;
                        fidx      <= '0;
                        eq        <= 1'b0;
                        lt        <= 1'b0;
                        gt        <= 1'b0;
                        mism_cnt  <= '0;
                        first_idx <= '0;
                    end
                end
                S_RUN: begin
                    if (xfer) begin
                        idx     <= idx + IW'(1);
                        decided <= decided_nxt;
                        dir_lt  <= dir_lt_nxt;
                        cnt     <= cnt_nxt;
                        fidx    <= fidx_nxt;
                        // Results are published together with the final word.
                        if (last_word) begin
                            state     <= S_DONE;
                            eq        <= ~decided_nxt;
                            lt        <= decided_nxt & dir_lt_nxt;
                            gt        <= decided_nxt & ~dir_lt_nxt;
                            mism_cnt  <= cnt_nxt;
                            first_idx <= fidx_nxt;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_cmp.sv
// Directed bench for stream_cmp: an unsigned and a signed instance share the same
// stimulus; a vector table plus hand sequences for reset, gaps and start filtering.
module tb_stream_cmp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, in_valid;
    logic [7:0] a, b;

    logic       in_ready_u, done_u, eq_u, lt_u, gt_u;
    logic [2:0] cnt_u;
    logic [1:0] fidx_u;
    logic       in_ready_s, done_s, eq_s, lt_s, gt_s;
    logic [2:0] cnt_s;
    logic [1:0] fidx_s;

    stream_cmp #(.W(8), .N(4), .SIGNED(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready_u), .a(a), .b(b), .done(done_u),
        .eq(eq_u), .lt(lt_u), .gt(gt_u), .mism_cnt(cnt_u), .first_idx(fidx_u)
    );

    stream_cmp #(.W(8), .N(4), .SIGNED(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready_s), .a(a), .b(b), .done(done_s),
        .eq(eq_s), .lt(lt_s), .gt(gt_s), .mism_cnt(cnt_s), .first_idx(fidx_s)
    );

    // res_* is {eq, lt, gt}; word 0 sits in bits [31:24]
    typedef struct packed {
        logic [31:0] wa;
        logic [31:0] wb;
        logic [2:0]  res_u;
        logic [2:0]  res_s;
        logic [2:0]  cnt;
        logic [1:0]  fidx;
    } vec_t;

    vec_t vecs[7];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run_frame(input vec_t v, input int gap, input bit poke_start,
                             input bit start_in_done);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ready_after_start", {31'd0, in_ready_u}, 32'd1);
        for (int w = 0; w < 4; w++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                start    = poke_start;
                @(posedge clk); #1;
            end
            start    = 1'b0;
            in_valid = 1'b1;
            a        = v.wa[31-8*w -: 8];
            b        = v.wb[31-8*w -: 8];
            if (w == 3) chk("done_early", {31'd0, done_u}, 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("done_u",      {31'd0, done_u},     32'd1);
        chk("done_s",      {31'd0, done_s},     32'd1);
        chk("ready_in_done", {31'd0, in_ready_u}, 32'd0);
        chk("res_u",  {29'd0, eq_u, lt_u, gt_u}, {29'd0, v.res_u});
        chk("res_s",  {29'd0, eq_s, lt_s, gt_s}, {29'd0, v.res_s});
        chk("cnt_u",  {29'd0, cnt_u},  {29'd0, v.cnt});
        chk("cnt_s",  {29'd0, cnt_s},  {29'd0, v.cnt});
        chk("fidx_u", {30'd0, fidx_u}, {30'd0, v.fidx});
        chk("fidx_s", {30'd0, fidx_s}, {30'd0, v.fidx});
        start = start_in_done;
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_pulse_end", {31'd0, done_u}, 32'd0);
        chk("no_start_from_done", {31'd0, in_ready_u}, 32'd0);
        chk("res_held", {29'd0, eq_u, lt_u, gt_u}, {29'd0, v.res_u});
    endtask

    initial begin
        vecs[0] = '{wa: 32'h11223344, wb: 32'h11223344, res_u: 3'b100, res_s: 3'b100, cnt: 3'd0, fidx: 2'd0};
        vecs[1] = '{wa: 32'h0A141E28, wb: 32'h0A191E29, res_u: 3'b010, res_s: 3'b010, cnt: 3'd2, fidx: 2'd1};
        vecs[2] = '{wa: 32'h80000000, wb: 32'h01000000, res_u: 3'b001, res_s: 3'b010, cnt: 3'd1, fidx: 2'd0};
        vecs[3] = '{wa: 32'h01FF0000, wb: 32'h01010000, res_u: 3'b001, res_s: 3'b001, cnt: 3'd1, fidx: 2'd1};
        vecs[4] = '{wa: 32'h05060708, wb: 32'h04090909, res_u: 3'b001, res_s: 3'b001, cnt: 3'd4, fidx: 2'd0};
        vecs[5] = '{wa: 32'h00000003, wb: 32'h00000007, res_u: 3'b010, res_s: 3'b010, cnt: 3'd1, fidx: 2'd3};
        vecs[6] = '{wa: 32'h7F000000, wb: 32'h80000000, res_u: 3'b010, res_s: 3'b001, cnt: 3'd1, fidx: 2'd0};

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; a = '0; b = '0;
        #12;
        chk("rst_ready", {31'd0, in_ready_u}, 32'd0);
        chk("rst_done",  {31'd0, done_u},     32'd0);
        chk("rst_res",   {29'd0, eq_u, lt_u, gt_u}, 32'd0);
        chk("rst_cnt",   {29'd0, cnt_u},  32'd0);
        chk("rst_fidx",  {30'd0, fidx_u}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // Words offered in IDLE must be ignored.
        in_valid = 1'b1; a = 8'h01; b = 8'h02;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("idle_ready", {31'd0, in_ready_u}, 32'd0);
        end
        in_valid = 1'b0;

        for (int i = 0; i < 7; i++) run_frame(vecs[i], 0, 1'b0, 1'b0);

        run_frame(vecs[1], 2, 1'b1, 1'b1);
        run_frame(vecs[5], 1, 1'b0, 1'b0);

        // Asynchronous reset clears held results without a clock edge.
        #3 rst_n = 1'b0;
        #1;
        chk("async_res", {29'd0, eq_u, lt_u, gt_u}, 32'd0);
        chk("async_cnt", {29'd0, cnt_u}, 32'd0);
        chk("async_fidx", {30'd0, fidx_u}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Abort a frame after two mismatching transfers.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1; a = 8'h01; b = 8'h02;
        repeat (2) begin @(posedge clk); #1; end
        #3 rst_n = 1'b0;
        #1;
        chk("abort_ready", {31'd0, in_ready_u}, 32'd0);
        chk("abort_cnt", {29'd0, cnt_u}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_idle", {31'd0, in_ready_u}, 32'd0);
        run_frame(vecs[0], 0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_cmp.md
# stream_cmp

Parametrised, sequential multi-word comparator. It accepts two operands as a frame of N words each, delivered one word pair per handshake, most significant word first. It reports equal, less-than and greater-than for the whole frame, plus the number of mismatching words and the index of the first mismatch. It is the clocked, streaming generalisation of the single-bit equality gate, used wherever wide values or buffers must be checked against each other word by word.

## Interface
- W, default 8: word width in bits, W ≥ 1.
- N, default 4: words per frame, N ≥ 2.
- SIGNED, default 0: 1 = the most significant word (index 0) is compared as two's complement; all other words are always unsigned.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- start  in  1  frame request; honoured only in IDLE.
- in_valid  in  1  a, b hold a valid word pair.
- in_ready  out  1  block accepts a word pair this cycle.
- a  in  W  operand A word.
- b  in  W  operand B word.
- done  out  1  one-cycle pulse; results valid.
- eq  out  1  frame A == frame B.
- lt  out  1  frame A < frame B.
- gt  out  1  frame A > frame B.
- mism_cnt  out  $clog2(N+1)  number of word indices where a ≠ b.
- first_idx  out  max(1,$clog2(N))  index of the first differing word; 0 when eq.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN when start=1. On this transition, clear eq/lt/gt/mism_cnt/first_idx to 0 and set the word index to 0.
  - RUN: in_ready=1. A transfer occurs when in_valid & in_ready.
  - RUN → DONE on the transfer of word N−1.
  - DONE → IDLE unconditionally after one cycle.
- start is ignored in RUN and DONE. It is not queued.
- Internal "decided" flag, cleared at frame start. On each transfer where a ≠ b:
  - increment the mismatch count;
  - if not yet decided: record first_idx = index, record the direction (lt or gt) from this word, set decided.
- Direction rule:
  - unsigned compare, except word 0 when SIGNED=1 (signed compare);
  - words after the deciding word never change the direction.
- Entering DONE:
  - eq = ~decided;
  - lt/gt = the recorded direction;
  - exactly one of eq/lt/gt is 1.
- Result outputs hold from done until the next accepted start, which clears them.
- mism_cnt saturates naturally at N, since it has no overflow at width $clog2(N+1).

## Timing
- Reset (async assert, sync release): state=IDLE; in_ready, done, eq, lt, gt, mism_cnt, first_idx all 0.
- start sampled at edge t → in_ready=1 from t+1.
- Zero-bubble frame: words accepted at edges t+1..t+N; done=1 during cycle t+N+1; in_ready=0 in that cycle.
- in_valid gaps stall the index; no timeout.
- Latency from last transfer to done is 1 cycle.
- start asserted while done=1 (DONE state) is ignored. Earliest new start is accepted in the cycle after done.
- in_valid while not in RUN: no transfer; inputs are ignored.
- Reset mid-frame: immediate return to IDLE with all outputs 0. The partial frame is discarded. The next start begins a fresh frame.
- Results are registered. eq/lt/gt/mism_cnt/first_idx are stable whenever done=1.

## Test plan
- Reset: assert rst_n=0 mid-cycle → all outputs 0 asynchronously; after release, in_ready stays 0 until start.
- Equal frame (W=8, N=4): start, then a=b={0x11,0x22,0x33,0x44} back-to-back → done exactly 5 cycles after the start edge; eq=1, lt=gt=0, mism_cnt=0, first_idx=0.
- Mixed mismatches: a={10,20,30,40}, b={10,25,30,41} → lt=1, eq=gt=0, mism_cnt=2, first_idx=1 (word 3 must not alter the direction).
- Backpressure/gaps: same frame as the mixed-mismatch case, with in_valid low for 2 cycles between each word → identical results; done 1 cycle after the 4th transfer; start pulsed during RUN has no effect.
- Signed mode: a={0x80,0,0,0}, b={0x01,0,0,0}:
  - SIGNED=0 → gt=1, first_idx=0, mism_cnt=1;
  - SIGNED=1 → lt=1;
  - also a={1,0xFF,..} vs b={1,0x01,..} with SIGNED=1 → gt=1 (word 1 compared unsigned).
- Reset mid-frame: after 2 transfers, pulse rst_n low → IDLE, outputs 0; a new full equal frame then yields eq=1, mism_cnt=0 with no residue from the aborted frame.
